tube_issue: RTL and testbench

//  Issue/writeback scheduler placed directly upstream of the execution tubes.

---
 rtl/tube_issue.sv | 103 ++++++++++
 tb/tb_tube_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tube_issue.sv
`timescale 1ns/1ps
// tube_issue
// Issue/writeback scheduler in front of the fast and slow execution tubes.
// It takes one op per cycle over valid/ready and steers it to the fast tube
// (latency FAST_LAT) or the slow tube (latency SLOW_LAT). When the op issues,
// the scheduler reserves the one register-file writeback slot for the cycle
// in which that op's result appears. It then replays {valid, sel, tag} in
// that cycle so the tube output can be written back.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   req_valid/req_ready      upstream op handshake
//   req_slow                 1 = slow tube, 0 = fast tube
//   req_data1/2, req_tag     operands and destination tag
//   fast_valid/slow_valid    in_valid strobes to the tubes
//   issue_data1/2            shared operand buses (pass-through)
//   wb_valid/wb_sel/wb_tag   writeback for the result on a tube output this cycle
//   busy                     some accepted op has not yet written back
module tube_issue #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned TAG_WIDTH = 5,
    parameter int unsigned FAST_LAT  = 1,
    parameter int unsigned SLOW_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_slow,
    input  logic [REG_WIDTH-1:0] req_data1,
    input  logic [REG_WIDTH-1:0] req_data2,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 fast_valid,
    output logic                 slow_valid,
    output logic [REG_WIDTH-1:0] issue_data1,
    output logic [REG_WIDTH-1:0] issue_data2,
    output logic                 wb_valid,
    output logic                 wb_sel,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic                 busy
);

    // Entry k describes the writeback in cycle t+k. Entry 0 is the current
    // cycle and drives wb_* directly from flops. The slot for t+SLOW_LAT lies
    // past the end of the pipeline. Nothing has a longer latency, so that slot
    // is always free, and a slow op can be blocked only by reset.
    logic [SLOW_LAT-1:0]  pv_q, pv_d;
    logic [SLOW_LAT-1:0]  ps_q, ps_d;
    logic [TAG_WIDTH-1:0] pt_q [SLOW_LAT];
    logic [TAG_WIDTH-1:0] pt_d [SLOW_LAT];
    logic                 accept;

    assign req_ready   = rst & (req_slow | ~pv_q[FAST_LAT]);
    assign accept      = req_valid & req_ready;
    assign fast_valid  = accept & ~req_slow;
    assign slow_valid  = accept & req_slow;
    assign issue_data1 = req_data1;
    assign issue_data2 = req_data2;

    assign wb_valid = pv_q[0];
    assign wb_sel   = ps_q[0];
    assign wb_tag   = pt_q[0];
    assign busy     = |pv_q;

    always_comb begin
        pv_d = pv_q >> 1;
        ps_d = ps_q >> 1;
        for (int i = 0; i < SLOW_LAT - 1; i++) begin
            pt_d[i] = pt_q[i+1];
        end
        pt_d[SLOW_LAT-1] = '0;
        // The accepted op lands in slot t+L. After the shift, that slot's
        // index is L-1.
        if (accept) begin
            if (req_slow) begin
                pv_d[SLOW_LAT-1] = 1'b1;
                ps_d[SLOW_LAT-1] = 1'b1;
                pt_d[SLOW_LAT-1] = req_tag;
            end else begin
                pv_d[FAST_LAT-1] = 1'b1;
                ps_d[FAST_LAT-1] = 1'b0;
                pt_d[FAST_LAT-1] = req_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pv_q <= '0;
            ps_q <= '0;
            for (int i = 0; i < SLOW_LAT; i++) begin
                pt_q[i] <= '0;
            end
        end else begin
            pv_q <= pv_d;
            ps_q <= ps_d;
            for (int i = 0; i < SLOW_LAT; i++) begin
                pt_q[i] <= pt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tube_issue.sv
`timescale 1ns/1ps
module tb_tube_issue;

    localparam int unsigned RW = 32;
    localparam int unsigned TW = 5;
    localparam int unsigned FL = 1;
    localparam int unsigned SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_slow;
    logic [RW-1:0] req_data1, req_data2;
    logic [TW-1:0] req_tag;
    logic          fast_valid, slow_valid;
    logic [RW-1:0] issue_data1, issue_data2;
    logic          wb_valid, wb_sel, busy;
    logic [TW-1:0] wb_tag;

    int vectors = 0;
    int errors  = 0;

    // Reference model for the random phase: reservations indexed by absolute cycle mod 8
    logic          rsv_v [8];
    logic          rsv_s [8];
    logic [TW-1:0] rsv_t [8];

    tube_issue #(
        .REG_WIDTH(RW),
        .TAG_WIDTH(TW),
        .FAST_LAT (FL),
        .SLOW_LAT (SL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_slow   (req_slow),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_tag    (req_tag),
        .fast_valid (fast_valid),
        .slow_valid (slow_valid),
        .issue_data1(issue_data1),
        .issue_data2(issue_data2),
        .wb_valid   (wb_valid),
        .wb_sel     (wb_sel),
        .wb_tag     (wb_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [TW-1:0] t);
        req_valid = v;
        req_slow  = s;
        req_tag   = t;
        req_data1 = 32'hA000_0000 | 32'(t);
        req_data2 = 32'h0B00_0000 | 32'(t);
        #1;
    endtask

    task automatic chk_wb(input string name, input logic v, input logic s, input logic [TW-1:0] t);
        chk({name, ".wb_valid"}, 32'(wb_valid), 32'(v));
        if (v) begin
            chk({name, ".wb_sel"}, 32'(wb_sel), 32'(s));
            chk({name, ".wb_tag"}, 32'(wb_tag), 32'(t));
        end
    endtask

    initial begin
        int unsigned cyc;
        logic        v, s, exp_rdy, exp_busy;
        logic [TW-1:0] t;
        int unsigned idx;

        // Reset phase: ready and issue strobes held low
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd0);
        tick();
        tick();
        drive(1'b1, 1'b1, 5'd0);
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.slow_valid", 32'(slow_valid), 32'd0);
        drive(1'b1, 1'b0, 5'd0);
        chk("rst.fast_valid", 32'(fast_valid), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_sel", 32'(wb_sel), 32'd0);
        chk("rst.wb_tag", 32'(wb_tag), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0);
        tick();

        // 1: back-to-back slow ops
        drive(1'b1, 1'b1, 5'd1);
        chk("t1.ready0", 32'(req_ready), 32'd1);
        chk("t1.slow_valid", 32'(slow_valid), 32'd1);
        chk("t1.fast_valid", 32'(fast_valid), 32'd0);
        chk("t1.data1", issue_data1, 32'hA000_0001);
        chk("t1.data2", issue_data2, 32'h0B00_0001);
        tick();
        drive(1'b1, 1'b1, 5'd2);
        chk("t1.ready1", 32'(req_ready), 32'd1);
        tick();
        drive(1'b1, 1'b1, 5'd3);
        chk("t1.ready2", 32'(req_ready), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0);
        chk_wb("t1.c3", 1'b0, 1'b0, 5'd0);
        chk("t1.busy3", 32'(busy), 32'd1);
        tick();
        chk_wb("t1.c4", 1'b1, 1'b1, 5'd1);
        tick();
        chk_wb("t1.c5", 1'b1, 1'b1, 5'd2);
        tick();
        chk_wb("t1.c6", 1'b1, 1'b1, 5'd3);
        tick();
        chk_wb("t1.c7", 1'b0, 1'b0, 5'd0);
        chk("t1.busy7", 32'(busy), 32'd0);

        // 2: fast op collides with slot held by slow op
        drive(1'b1, 1'b1, 5'd7);
        tick();
        drive(1'b0, 1'b0, 5'd0);
        tick();
        tick();
        drive(1'b1, 1'b0, 5'd9);
        chk("t2.ready3", 32'(req_ready), 32'd0);
        chk("t2.fast_valid3", 32'(fast_valid), 32'd0);
        tick();
        chk("t2.ready4", 32'(req_ready), 32'd1);
        chk("t2.fast_valid4", 32'(fast_valid), 32'd1);
        chk_wb("t2.c4", 1'b1, 1'b1, 5'd7);
        tick();
        drive(1'b0, 1'b0, 5'd0);
        chk_wb("t2.c5", 1'b1, 1'b0, 5'd9);
        tick();
        chk_wb("t2.c6", 1'b0, 1'b0, 5'd0);

        // 3: out-of-order writeback, busy span
        drive(1'b1, 1'b1, 5'd4);
        tick();
        drive(1'b1, 1'b0, 5'd5);
        chk("t3.ready1", 32'(req_ready), 32'd1);
        chk("t3.busy1", 32'(busy), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0);
        chk_wb("t3.c2", 1'b1, 1'b0, 5'd5);
        chk("t3.busy2", 32'(busy), 32'd1);
        tick();
        chk_wb("t3.c3", 1'b0, 1'b0, 5'd0);
        chk("t3.busy3", 32'(busy), 32'd1);
        tick();
        chk_wb("t3.c4", 1'b1, 1'b1, 5'd4);
        chk("t3.busy4", 32'(busy), 32'd1);
        tick();
        chk_wb("t3.c5", 1'b0, 1'b0, 5'd0);
        chk("t3.busy5", 32'(busy), 32'd0);

        // 4: reset drops in-flight ops
        drive(1'b1, 1'b1, 5'd10);
        tick();
        drive(1'b1, 1'b1, 5'd11);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd12);
        chk("t4.rst_ready", 32'(req_ready), 32'd0);
        chk("t4.rst_fast", 32'(fast_valid), 32'd0);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0);
        chk("t4.busy3", 32'(busy), 32'd0);
        for (int c = 3; c <= 8; c++) begin
            if (c == 8) drive(1'b1, 1'b0, 5'd13);
            chk("t4.wb_valid_quiet", 32'(wb_valid), 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0);
        chk_wb("t4.fresh", 1'b1, 1'b0, 5'd13);
        tick();

        // 5: ready follows req_slow while slot t+1 is reserved
        drive(1'b1, 1'b1, 5'd21);
        tick();
        drive(1'b0, 1'b0, 5'd0);
        tick();
        tick();
        drive(1'b1, 1'b0, 5'd30);
        chk("t5.ready_f0", 32'(req_ready), 32'd0);
        drive(1'b1, 1'b1, 5'd31);
        chk("t5.ready_s0", 32'(req_ready), 32'd1);
        chk("t5.slow_valid", 32'(slow_valid), 32'd1);
        drive(1'b1, 1'b0, 5'd30);
        chk("t5.ready_f1", 32'(req_ready), 32'd0);
        chk("t5.fast_valid", 32'(fast_valid), 32'd0);
        drive(1'b0, 1'b1, 5'd31);
        chk("t5.idle_slow_valid", 32'(slow_valid), 32'd0);
        tick();
        drive(1'b1, 1'b1, 5'd22);
        chk_wb("t5.c4", 1'b1, 1'b1, 5'd21);
        tick();
        drive(1'b0, 1'b0, 5'd0);
        tick();
        tick();
        chk_wb("t5.c7", 1'b0, 1'b0, 5'd0);
        tick();
        chk_wb("t5.c8", 1'b1, 1'b1, 5'd22);
        tick();
        chk("t5.busy9", 32'(busy), 32'd0);

        // 6: random mix against the reservation model
        for (int i = 0; i < 8; i++) begin
            rsv_v[i] = 1'b0;
            rsv_s[i] = 1'b0;
            rsv_t[i] = '0;
        end
        for (cyc = 0; cyc < 2000 + SL + 1; cyc++) begin
            idx = cyc % 8;
            exp_busy = 1'b0;
            for (int i = 0; i < 8; i++) exp_busy |= rsv_v[i];
            chk("t6.busy", 32'(busy), 32'(exp_busy));
            chk_wb("t6.wb", rsv_v[idx], rsv_s[idx], rsv_t[idx]);
            rsv_v[idx] = 1'b0;
            v = (cyc < 2000) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            s = 1'($urandom_range(0, 1));
            t = TW'($urandom);
            drive(v, s, t);
            idx = (cyc + (s ? SL : FL)) % 8;
            exp_rdy = !rsv_v[idx];
            if (v) chk("t6.ready", 32'(req_ready), 32'(exp_rdy));
            chk("t6.fast_valid", 32'(fast_valid), 32'(v & exp_rdy & !s));
            chk("t6.slow_valid", 32'(slow_valid), 32'(v & exp_rdy & s));
            if (v && exp_rdy) begin
                rsv_v[idx] = 1'b1;
                rsv_s[idx] = s;
                rsv_t[idx] = t;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
